// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus bundle for the register-file write-port arbiter.
// The slave modport faces the arbiter; the master modport faces the core/MDU side.
interface regfile_wb_arbiter_if;
    logic        pipe_wb_valid;
    logic [4:0]  pipe_wb_addr;
    logic [31:0] pipe_wb_data;
    logic        mdu_wb_valid;
    logic        mdu_wb_ready;
    logic [4:0]  mdu_wb_addr;
    logic [31:0] mdu_wb_data;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic        rs1_busy;
    logic        rs2_busy;
    logic        stall_req;
    logic        RegWrite;
    logic [4:0]  WriteAddr;
    logic [31:0] WriteData;

    modport slave (
        input  pipe_wb_valid, pipe_wb_addr, pipe_wb_data,
        input  mdu_wb_valid, mdu_wb_addr, mdu_wb_data,
        input  issue_valid, issue_rd, rs1_addr, rs2_addr,
        output mdu_wb_ready, rs1_busy, rs2_busy, stall_req,
        output RegWrite, WriteAddr, WriteData
    );

    modport master (
        output pipe_wb_valid, pipe_wb_addr, pipe_wb_data,
        output mdu_wb_valid, mdu_wb_addr, mdu_wb_data,
        output issue_valid, issue_rd, rs1_addr, rs2_addr,
        input  mdu_wb_ready, rs1_busy, rs2_busy, stall_req,
        input  RegWrite, WriteAddr, WriteData
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Merges pipeline WB and MDU results onto the single register-file write port,
// and keeps a pending-destination scoreboard for MDU RAW hazard detection.
module regfile_wb_arbiter #(
    parameter int MAX_WAIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    regfile_wb_arbiter_if.slave   bus
);
    localparam int CW = $clog2(MAX_WAIT) + 1;

    typedef enum logic [1:0] {IDLE, HELD, FORCE} state_t;

    state_t        state, state_next;
    logic [CW-1:0] wait_cnt, wait_cnt_next;
    logic [4:0]    hold_addr;
    logic [31:0]   hold_data;
    logic          hold_load;
    logic [31:0]   pending, pending_next;
    logic          we_next;
    logic [4:0]    waddr_next;
    logic [31:0]   wdata_next;
    logic          clr_valid;
    logic [4:0]    clr_addr;
    logic          reg_write;
    logic [4:0]    write_addr;
    logic [31:0]   write_data;

    assign bus.mdu_wb_ready = (state == IDLE);
    assign bus.stall_req    = (state == FORCE);
    assign bus.RegWrite     = reg_write;
    assign bus.WriteAddr    = write_addr;
    assign bus.WriteData    = write_data;
    assign bus.rs1_busy     = pending[bus.rs1_addr];
    assign bus.rs2_busy     = pending[bus.rs2_addr];

    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        hold_load     = 1'b0;
        we_next       = 1'b0;
        waddr_next    = 5'd0;
        wdata_next    = 32'd0;
        clr_valid     = 1'b0;
        clr_addr      = 5'd0;

        // The pipeline owns the port whenever it is valid, even for a discarded x0 write.
        if (bus.pipe_wb_valid && (bus.pipe_wb_addr != 5'd0)) begin
            we_next    = 1'b1;
            waddr_next = bus.pipe_wb_addr;
            wdata_next = bus.pipe_wb_data;
        end

        case (state)
            IDLE: begin
                if (bus.mdu_wb_valid && (bus.mdu_wb_addr != 5'd0)) begin
                    if (bus.pipe_wb_valid) begin
                        hold_load     = 1'b1;
                        wait_cnt_next = '0;
                        state_next    = HELD;
                    end else begin
                        we_next    = 1'b1;
                        waddr_next = bus.mdu_wb_addr;
                        wdata_next = bus.mdu_wb_data;
                        clr_valid  = 1'b1;
                        clr_addr   = bus.mdu_wb_addr;
                    end
                end
            end
            HELD, FORCE: begin
                if (!bus.pipe_wb_valid) begin
                    we_next       = 1'b1;
                    waddr_next    = hold_addr;
                    wdata_next    = hold_data;
                    clr_valid     = 1'b1;
                    clr_addr      = hold_addr;
                    wait_cnt_next = '0;
                    state_next    = IDLE;
                end else if (state == HELD) begin
                    if (wait_cnt == CW'(MAX_WAIT - 1)) begin
                        state_next = FORCE;
                    end
                    if (wait_cnt < CW'(MAX_WAIT)) begin
                        wait_cnt_next = wait_cnt + CW'(1);
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // A new issue to the same register on the clearing edge must stay pending.
    always_comb begin
        pending_next = pending;
        if (clr_valid) begin
            pending_next[clr_addr] = 1'b0;
        end
        if (bus.issue_valid && (bus.issue_rd != 5'd0)) begin
            pending_next[bus.issue_rd] = 1'b1;
        end
        pending_next[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            wait_cnt   <= '0;
            hold_addr  <= 5'd0;
            hold_data  <= 32'd0;
            pending    <= 32'd0;
            reg_write  <= 1'b0;
            write_addr <= 5'd0;
            write_data <= 32'd0;
        end else begin
            state      <= state_next;
            wait_cnt   <= wait_cnt_next;
            pending    <= pending_next;
            reg_write  <= we_next;
            write_addr <= waddr_next;
            write_data <= wdata_next;
            if (hold_load) begin
                hold_addr <= bus.mdu_wb_addr;
                hold_data <= bus.mdu_wb_data;
            end
        end
    end
endmodule
